// File: rtl/icache_fetch.sv
// icache_fetch: direct-mapped instruction cache for the fetch stage.
// Hits return combinationally; a miss refills one line word-by-word over a
// single-beat AXI read channel and then replays the request.
// Optional build macro ICACHE_STATS_EN adds hit_count / miss_count.
module icache_fetch #(
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [31:0] req_addr,
   input  logic        invalidate,
   output logic        rsp_valid,
   output logic [31:0] rsp_instr,
   output logic        stall,
   output logic        cache_miss_detected,
   output logic        refill_complete,
`ifdef ICACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   output logic [31:0] ARADDR,
   output logic        ARVALID,
   input  logic        ARREADY,
   input  logic [31:0] RDATA,
   input  logic        RVALID,
   output logic        RREADY
);
   localparam int OB = $clog2(WORDS);
   localparam int IB = $clog2(LINES);
   localparam int TW = 32 - IB - OB - 2;
   localparam int KW = (OB > 0) ? OB : 1;

   typedef enum logic [1:0] {IDLE, AR, R, FILL} state_t;

   state_t           state, state_nxt;
   logic [LINES-1:0] valid;
   logic [TW-1:0]    tag_mem  [LINES];
   logic [31:0]      data_mem [LINES][WORDS];
   logic [31:0]      base;
   logic [KW-1:0]    k;
   logic             inv_pend;

   logic [IB-1:0] req_idx, base_idx;
   logic [TW-1:0] req_tag, base_tag;
   logic [KW-1:0] req_off;
   logic          hit, miss, last_beat;
   logic          unused_addr_bits;

   assign req_idx  = req_addr[IB+OB+1:OB+2];
   assign req_tag  = req_addr[31:IB+OB+2];
   assign base_idx = base[IB+OB+1:OB+2];
   assign base_tag = base[31:IB+OB+2];
   assign unused_addr_bits = &{1'b0, req_addr[1:0]};

   generate
      if (OB > 0) begin : g_off
         assign req_off = req_addr[OB+1:2];
      end else begin : g_no_off
         assign req_off = '0;
      end
   endgenerate

   // Lookup uses the valid bits as they stand this cycle, so an invalidate
   // arriving with a request does not affect that request.
   assign hit       = (state == IDLE) && req_valid && valid[req_idx] &&
                      (tag_mem[req_idx] == req_tag);
   assign miss      = (state == IDLE) && req_valid && !hit;
   assign last_beat = (k == KW'(WORDS - 1));

   // Next state and all handshake/status outputs.
   always_comb begin
      state_nxt           = state;
      rsp_valid           = hit;
      rsp_instr           = hit ? data_mem[req_idx][req_off] : '0;
      stall               = (state != IDLE) || miss;
      cache_miss_detected = miss;
      refill_complete     = (state == FILL);
      ARVALID             = (state == AR);
      RREADY              = (state == R);
      ARADDR              = base | (32'(k) << 2);
      case (state)
         IDLE:    if (miss) state_nxt = AR;
         AR:      if (ARREADY) state_nxt = R;
         R:       if (RVALID) state_nxt = last_beat ? FILL : AR;
         FILL:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Control state: FSM, valid bits, line base, beat counter, pending invalidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         valid    <= '0;
         base     <= '0;
         k        <= '0;
         inv_pend <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (miss) begin
                  base           <= {req_addr[31:OB+2], {(OB+2){1'b0}}};
                  k              <= '0;
                  valid[req_idx] <= 1'b0;
               end
               if (invalidate) valid <= '0;
            end
            AR, R: begin
               if (state == R && RVALID && !last_beat) k <= k + 1'b1;
               if (invalidate) inv_pend <= 1'b1;
            end
            FILL: begin
               // A flush seen during the refill wins over installing the line.
               if (inv_pend || invalidate) valid <= '0;
               else                        valid[base_idx] <= 1'b1;
               inv_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Data and tag arrays are not reset; valid bits gate their use.
   always_ff @(posedge clk) begin
      if (!rst && state == R && RVALID) begin
         data_mem[base_idx][k] <= RDATA;
         tag_mem[base_idx]     <= base_tag;
      end
   end

`ifdef ICACHE_STATS_EN
   // Event counters; the replayed request after a refill counts as a hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (hit)  hit_count  <= hit_count + 32'd1;
         if (miss) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch with a delay-configurable AXI read slave.
// Expected instructions and AR addresses are queued when a fetch is issued
// and popped as the DUT responds.
module tb_icache_fetch;
   logic        clk, rst;
   logic        req_valid, invalidate;
   logic [31:0] req_addr;
   logic        rsp_valid, stall, cache_miss_detected, refill_complete;
   logic [31:0] rsp_instr;
   logic [31:0] ARADDR, RDATA;
   logic        ARVALID, ARREADY, RVALID, RREADY;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   icache_fetch #(.LINES(16), .WORDS(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_addr(req_addr), .invalidate(invalidate),
      .rsp_valid(rsp_valid), .rsp_instr(rsp_instr), .stall(stall),
      .cache_miss_detected(cache_miss_detected), .refill_complete(refill_complete),
`ifdef ICACHE_STATS_EN
      .hit_count(hit_count), .miss_count(miss_count),
`endif
      .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RVALID(RVALID), .RREADY(RREADY)
   );

   int tests = 0;
   int fails = 0;
   logic [31:0] exp_q[$];
   logic [31:0] ar_q[$];
   int ar_delay = 0, r_delay = 0;
   int miss_pulses = 0, refill_pulses = 0, viol = 0;
   logic prev_ar_wait = 1'b0, prev_r_wait = 1'b0;
   logic [31:0] prev_araddr = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // AXI read slave: decides ARREADY/RVALID for the coming edge at each negedge.
   initial begin
      automatic int ar_cnt = 0, r_cnt = 0;
      automatic logic r_pend = 1'b0;
      automatic logic [31:0] r_addr = '0;
      ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0;
      forever begin
         @(negedge clk);
         ARREADY = 1'b0;
         RVALID  = 1'b0;
         if (rst) begin
            r_pend = 1'b0; ar_cnt = 0; r_cnt = 0;
         end else if (ARVALID) begin
            if (ar_cnt < ar_delay) ar_cnt++;
            else begin
               ARREADY = 1'b1; ar_cnt = 0; r_addr = ARADDR; r_pend = 1'b1;
               check("ar_expected", 32'(ar_q.size() != 0), 32'd1);
               if (ar_q.size() != 0) check("araddr", ARADDR, ar_q.pop_front());
            end
         end else if (RREADY && r_pend) begin
            if (r_cnt < r_delay) r_cnt++;
            else begin
               RVALID = 1'b1; RDATA = mem(r_addr); r_pend = 1'b0; r_cnt = 0;
            end
         end
      end
   end

   // Pulse counting and AXI protocol watch.
   always @(posedge clk) begin
      if (!rst) begin
         miss_pulses   <= miss_pulses + int'(cache_miss_detected);
         refill_pulses <= refill_pulses + int'(refill_complete);
         if (ARVALID && RREADY) viol <= viol + 1;
         if (prev_ar_wait && (!ARVALID || ARADDR !== prev_araddr)) viol <= viol + 1;
         if (prev_r_wait && !RREADY) viol <= viol + 1;
      end
      prev_ar_wait <= ARVALID && !ARREADY;
      prev_r_wait  <= RREADY && !RVALID;
      prev_araddr  <= ARADDR;
   end

   // Issue one fetch; fills = expected line refills, inv_at = cycle offset
   // (0 = request cycle) at which to pulse invalidate, -1 for none.
   task automatic fetch(input logic [31:0] a, input int exp_n, input int fills,
                        input int inv_at, input string tag);
      int n, m0, r0;
      logic [31:0] exp;
      @(negedge clk);
      m0 = miss_pulses; r0 = refill_pulses;
      for (int f = 0; f < fills; f++)
         for (int w = 0; w < 4; w++) ar_q.push_back({a[31:4], 4'h0} + 32'(4 * w));
      exp_q.push_back(mem({a[31:2], 2'b00}));
      req_valid = 1'b1; req_addr = a; invalidate = (inv_at == 0);
      n = 0;
      #1;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
         invalidate = (n == inv_at);
         #1;
      end
      exp = exp_q.pop_front();
      check({tag, "_stall_cycles"}, 32'(n), 32'(exp_n));
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
      if (rsp_valid) begin
         check({tag, "_instr"}, rsp_instr, exp);
         check({tag, "_stall_at_rsp"}, 32'(stall), 32'd0);
      end
      check({tag, "_miss_pulses"}, 32'(miss_pulses - m0), 32'(fills));
      check({tag, "_refill_pulses"}, 32'(refill_pulses - r0), 32'(fills));
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0; invalidate = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; invalidate = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_arvalid", 32'(ARVALID), 32'd0);
      check("rst_rready", 32'(RREADY), 32'd0);
      check("rst_araddr", ARADDR, 32'd0);
      check("rst_miss", 32'(cache_miss_detected), 32'd0);
      check("rst_refill", 32'(refill_complete), 32'd0);
`ifdef ICACHE_STATS_EN
      check("rst_hit_count", hit_count, 32'd0);
      check("rst_miss_count", miss_count, 32'd0);
`endif
      // Cold miss, then hits in the same line on consecutive cycles.
      fetch(32'h0000_0008, 10, 1, -1, "cold");
      fetch(32'h0000_0000, 0, 0, -1, "hit0");
      fetch(32'h0000_0004, 0, 0, -1, "hit4");
      fetch(32'h0000_000C, 0, 0, -1, "hitC");
      idle();
`ifdef ICACHE_STATS_EN
      check("stats_hit_count", hit_count, 32'd4);
      check("stats_miss_count", miss_count, 32'd1);
`endif
      // Conflict eviction on index 0.
      fetch(32'h0000_0100, 10, 1, -1, "evict");
      fetch(32'h0000_0000, 10, 1, -1, "reevict");
      // Invalidate alongside a hit: lookup uses old valid bits, next one misses.
      fetch(32'h0000_0004, 0, 0, 0, "inv_idle_hit");
      fetch(32'h0000_0004, 10, 1, -1, "inv_idle_miss");
      // AR held off 3 cycles, R delayed 2 cycles per beat.
      ar_delay = 3; r_delay = 2;
      fetch(32'h0000_0024, 30, 1, -1, "backpressure");
      ar_delay = 0; r_delay = 0;
      // Invalidate during beat 2 forces a second refill of the same line.
      fetch(32'h0000_0048, 20, 2, 5, "inv_refill");
      idle();
      check("protocol_violations", 32'(viol), 32'd0);
      check("ar_queue_drained", 32'(ar_q.size()), 32'd0);
      check("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
